mem_port_ctrl: RTL and testbench

Initiator-side controller for one port of the fixed-latency word memory: it accepts single-word requests from a cache/CPU datapath over a valid/ready handshake and drives the memory port's `readM`/`writeM`/address/bidirectional data bus. The memory has no ready signal, so the controller times every access with its own latency counter and captures read data itself. One instance serves the instruction port and one serves the data port. Optional burst mode fills a whole aligned line per read for the cache.

---
 rtl/mem_port_ctrl_if.sv | 25 ++
 rtl/mem_port_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: single-word request/response handshake between a
// cache/CPU datapath (master) and mem_port_ctrl (slave).
interface mem_port_ctrl_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);
  logic                            req_valid;
  logic                            req_ready;
  logic                            req_write;
  logic [WORD_SIZE-1:0]            req_addr;
  logic [WORD_SIZE-1:0]            req_wdata;
  logic                            resp_valid;
  logic [WORD_SIZE-1:0]            resp_rdata;
  logic [WORD_SIZE*LINE_WORDS-1:0] resp_line;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_line
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_line
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: initiator-side controller for one port of a fixed-latency
// word memory with no ready signal. Each access holds readM/writeM and the
// address for LATENCY+1 cycles, and read data is captured on the last of them.
// Define MEM_PORT_BURST_EN to make reads fill a whole aligned line of
// LINE_WORDS words (one idle GAP cycle between beats); otherwise reads are
// single-word and resp_line is tied to zero.
module mem_port_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int LATENCY    = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_port_ctrl_if.slave       port,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data
);
  localparam int CNT_W = $clog2(LATENCY + 2);
`ifdef MEM_PORT_BURST_EN
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, RESP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 readM_q, readM_d;
  logic                 writeM_q, writeM_d;
  logic [WORD_SIZE-1:0] address_q, address_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic                 last_beat;
`ifdef MEM_PORT_BURST_EN
  logic [BEAT_W-1:0]                    beat_q, beat_d;
  logic [WORD_SIZE-1:0]                 addr_q, addr_d;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] line_q, line_d;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] resp_line_q, resp_line_d;
`endif

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    readM_d      = readM_q;
    writeM_d     = writeM_q;
    address_d    = address_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
`ifdef MEM_PORT_BURST_EN
    beat_d       = beat_q;
    addr_d       = addr_q;
    line_d       = line_q;
    resp_line_d  = resp_line_q;
    last_beat    = write_q || (beat_q == BEAT_W'(LINE_WORDS - 1));
`else
    last_beat    = 1'b1;
`endif

    unique case (state_q)
      IDLE: begin
        if (port.req_valid) begin
          state_d     = ACCESS;
          req_ready_d = 1'b0;
          write_d     = port.req_write;
          wdata_d     = port.req_wdata;
          cnt_d       = '0;
          readM_d     = !port.req_write;
          writeM_d    = port.req_write;
`ifdef MEM_PORT_BURST_EN
          beat_d      = '0;
          addr_d      = port.req_addr;
          // reads start at the line base so a burst never crosses a line
          address_d   = port.req_write ? port.req_addr
                      : {port.req_addr[WORD_SIZE-1:BEAT_W], {BEAT_W{1'b0}}};
`else
          address_d   = port.req_addr;
`endif
        end
      end

      ACCESS: begin
        if (cnt_q == CNT_W'(LATENCY)) begin
          readM_d  = 1'b0;
          writeM_d = 1'b0;
          if (!write_q) begin
`ifdef MEM_PORT_BURST_EN
            line_d[beat_q] = data;
            if (last_beat) begin
              resp_line_d  = line_d;
              resp_rdata_d = line_d[addr_q[BEAT_W-1:0]];
            end
`else
            resp_rdata_d = data;
`endif
          end
          if (last_beat) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        state_d   = ACCESS;
        cnt_d     = '0;
        readM_d   = 1'b1;
`ifdef MEM_PORT_BURST_EN
        beat_d    = beat_q + BEAT_W'(1);
        address_d = {addr_q[WORD_SIZE-1:BEAT_W], beat_d};
`endif
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops commands and releases the bus at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      readM_q      <= 1'b0;
      writeM_q     <= 1'b0;
      address_q    <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MEM_PORT_BURST_EN
      beat_q       <= '0;
      addr_q       <= '0;
      line_q       <= '0;
      resp_line_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      readM_q      <= readM_d;
      writeM_q     <= writeM_d;
      address_q    <= address_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef MEM_PORT_BURST_EN
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      resp_line_q  <= resp_line_d;
`endif
    end
  end

  assign readM           = readM_q;
  assign writeM          = writeM_q;
  assign address         = address_q;
  assign data            = writeM_q ? wdata_q : 'z;
  assign port.req_ready  = req_ready_q;
  assign port.resp_valid = resp_valid_q;
  assign port.resp_rdata = resp_rdata_q;
`ifdef MEM_PORT_BURST_EN
  assign port.resp_line  = resp_line_q;
`else
  assign port.resp_line  = {(WORD_SIZE*LINE_WORDS){1'b0}};
`endif
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: bench for mem_port_ctrl with a fixed-latency memory model
// (valid read data only on the LATENCY-th cycle of a continuous readM), a
// pulled-up data bus, a request table and hand-written reset/back-to-back cases.
module tb_mem_port_ctrl;
  localparam int W   = 16;
  localparam int LAT = 2;
  localparam int LW  = 4;
`ifdef MEM_PORT_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int RD_RESP = BURST ? LW*(LAT+1) + LW : LAT + 2;
  localparam int RD_CMD  = BURST ? LW*(LAT+1) : LAT + 1;
  localparam int WR_RESP = LAT + 2;
  localparam int WR_CMD  = LAT + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         readM, writeM;
  logic [W-1:0] address;
  tri1  [W-1:0] data;

  mem_port_ctrl_if #(.WORD_SIZE(W), .LINE_WORDS(LW)) port ();

  mem_port_ctrl #(.WORD_SIZE(W), .LATENCY(LAT), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset_n(reset_n), .port(port),
    .readM(readM), .writeM(writeM), .address(address), .data(data)
  );

  always #5 clk = ~clk;

  // memory model
  logic [W-1:0] mem     [0:65535];
  logic [W-1:0] ref_mem [0:65535];
  int unsigned  mcnt = 0;
  always @(posedge clk) mcnt <= readM ? mcnt + 1 : 0;
  always @(posedge clk) if (writeM) mem[address] <= data;
  assign data = readM ? ((mcnt == LAT) ? mem[address] : 16'hDEAD) : 'z;

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // scoreboard
  typedef struct {
    logic            wr;
    logic [W-1:0]    rdata;
    logic [W*LW-1:0] line;
    string           nm;
  } exp_t;
  exp_t         sb[$];
  logic [W-1:0] last_rdata = '0;
  logic         mon_en = 1'b0;
  int           overlap = 0;

  function automatic logic [W*LW-1:0] exp_line(input logic [W-1:0] a);
    logic [W*LW-1:0] l;
    logic [W-1:0]    base;
    l = '0;
    if (BURST) begin
      base = a & ~W'(LW-1);
      for (int k = 0; k < LW; k++) l[k*W +: W] = ref_mem[base + W'(k)];
    end
    return l;
  endfunction

  task automatic push_exp(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                          input logic [W-1:0] exp_rd, input string nm);
    exp_t e;
    e.wr = wr;
    e.nm = nm;
    if (wr) begin
      ref_mem[a] = wd;
      e.rdata = last_rdata;
      e.line  = '0;
    end else begin
      last_rdata = exp_rd;
      e.rdata = exp_rd;
      e.line  = exp_line(a);
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (readM && writeM) overlap++;
      if (port.resp_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, "_rdata"}, 64'(port.resp_rdata), 64'(e.rdata));
          if (!e.wr) chk({e.nm, "_line"}, 64'(port.resp_line), 64'(e.line));
        end
      end
    end
  end

  task automatic start_req(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                           input string nm, input bit keep_valid);
    int n;
    bit ok;
    port.req_valid = 1'b1;
    port.req_write = wr;
    port.req_addr  = a;
    port.req_wdata = wd;
    n  = 0;
    ok = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (port.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_accepted"}, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) port.req_valid = 1'b0;
  endtask

  task automatic time_txn(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                          input int exp_resp, input int exp_cmd, input string nm);
    int resp_c, cmd_c, bus_err, rdy_err;
    logic [W-1:0] exp_addr;
    resp_c = 0; cmd_c = 0; bus_err = 0; rdy_err = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (readM || writeM) begin
        if (!wr && BURST) exp_addr = (a & ~W'(LW-1)) | W'(cmd_c / (LAT+1));
        else              exp_addr = a;
        if (address !== exp_addr) bus_err++;
        if (wr && (!writeM || readM || data !== wd)) bus_err++;
        if (!wr && (!readM || writeM)) bus_err++;
        cmd_c++;
      end
      if (port.req_ready) rdy_err++;
      if (port.resp_valid) begin
        resp_c = c;
        break;
      end
    end
    chk({nm, "_resp_cycle"}, 64'(resp_c), 64'(exp_resp));
    chk({nm, "_cmd_cycles"}, 64'(cmd_c), 64'(exp_cmd));
    chk({nm, "_bus_errs"}, 64'(bus_err), 64'd0);
    chk({nm, "_ready_high_while_busy"}, 64'(rdy_err), 64'd0);
  endtask

  task automatic run_txn(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                         input logic [W-1:0] exp_rd, input string nm);
    push_exp(wr, a, wd, exp_rd, nm);
    start_req(wr, a, wd, nm, 1'b0);
    time_txn(wr, a, wd, wr ? WR_RESP : RD_RESP, wr ? WR_CMD : RD_CMD, nm);
  endtask

  task automatic pre(input logic [W-1:0] a, input logic [W-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  typedef struct {
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_rdata;
    string        nm;
  } vec_t;

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   rv;

    port.req_valid = 1'b0;
    port.req_write = 1'b0;
    port.req_addr  = '0;
    port.req_wdata = '0;

    pre(16'h0000, 16'h1111); pre(16'h0001, 16'h1112); pre(16'h0002, 16'h1113); pre(16'h0003, 16'h1114);
    pre(16'h0010, 16'h0000); pre(16'h0011, 16'h0000); pre(16'h0012, 16'h0000); pre(16'h0013, 16'h0000);
    pre(16'h0020, 16'hA020); pre(16'h0021, 16'hA021); pre(16'h0022, 16'hA022); pre(16'h0023, 16'h6000);
    pre(16'h0024, 16'hF01C); pre(16'h0025, 16'h6100); pre(16'h0026, 16'hF41C); pre(16'h0027, 16'h6200);
    pre(16'hFFFC, 16'hC0FC); pre(16'hFFFD, 16'hC0FD); pre(16'hFFFE, 16'hC0FE); pre(16'hFFFF, 16'hC0FF);

    v = '{1'b0, 16'h0023, 16'h0000, 16'h6000, "rd_0023"};   tbl.push_back(v);
    v = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, "wr_0010"};   tbl.push_back(v);
    v = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, "rd_0010"};   tbl.push_back(v);
    v = '{1'b0, 16'h0025, 16'h0000, 16'h6100, "rd_0025"};   tbl.push_back(v);
    v = '{1'b1, 16'h0011, 16'h1234, 16'h0000, "wr_0011"};   tbl.push_back(v);
    v = '{1'b0, 16'h0011, 16'h0000, 16'h1234, "rd_0011"};   tbl.push_back(v);
    v = '{1'b0, 16'hFFFF, 16'h0000, 16'hC0FF, "rd_ffff"};   tbl.push_back(v);
    v = '{1'b1, 16'hFFFE, 16'hA5A5, 16'h0000, "wr_fffe"};   tbl.push_back(v);
    v = '{1'b0, 16'hFFFE, 16'h0000, 16'hA5A5, "rd_fffe"};   tbl.push_back(v);
    v = '{1'b0, 16'h0000, 16'h0000, 16'h1111, "rd_0000"};   tbl.push_back(v);

    // reset state, checked asynchronously between clock edges
    #3 reset_n = 1'b0;
    #1;
    chk("rst_req_ready",  64'(port.req_ready),  64'd1);
    chk("rst_readM",      64'(readM),           64'd0);
    chk("rst_writeM",     64'(writeM),          64'd0);
    chk("rst_resp_valid", 64'(port.resp_valid), 64'd0);
    chk("rst_address",    64'(address),         64'd0);
    chk("rst_resp_rdata", 64'(port.resp_rdata), 64'd0);
    chk("rst_resp_line",  64'(port.resp_line),  64'd0);
    chk("rst_data_released", 64'(data), 64'hFFFF);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].nm);

    // back-to-back: second request held valid throughout the first
    push_exp(1'b0, 16'h0023, 16'h0000, 16'h6000, "b2b_rd");
    push_exp(1'b1, 16'h0012, 16'h5A5A, 16'h0000, "b2b_wr");
    start_req(1'b0, 16'h0023, 16'h0000, "b2b_rd", 1'b1);
    port.req_write = 1'b1;
    port.req_addr  = 16'h0012;
    port.req_wdata = 16'h5A5A;
    time_txn(1'b0, 16'h0023, 16'h0000, RD_RESP, RD_CMD, "b2b_rd");
    @(negedge clk);
    chk("b2b_ready_after_resp", 64'(port.req_ready), 64'd1);
    @(posedge clk);
    #1 port.req_valid = 1'b0;
    time_txn(1'b1, 16'h0012, 16'h5A5A, WR_RESP, WR_CMD, "b2b_wr");
    run_txn(1'b0, 16'h0012, 16'h0000, 16'h5A5A, "b2b_readback");

    // reset in the middle of a write
    start_req(1'b1, 16'h0040, 16'h7777, "rstw", 1'b0);
    repeat (2) @(negedge clk);
    chk("rstw_writeM_before", 64'(writeM), 64'd1);
    chk("rstw_data_before",   64'(data),   64'h7777);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_writeM_now",  64'(writeM),          64'd0);
    chk("rstw_readM_now",   64'(readM),           64'd0);
    chk("rstw_data_now",    64'(data),            64'hFFFF);
    chk("rstw_ready_now",   64'(port.req_ready),  64'd1);
    chk("rstw_resp_now",    64'(port.resp_valid), 64'd0);
    sb.delete();
    last_rdata = '0;
    rv = 0;
    repeat (3) begin
      @(negedge clk);
      if (port.resp_valid) rv++;
    end
    #2 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (port.resp_valid) rv++;
    end
    chk("rstw_no_resp", 64'(rv), 64'd0);
    chk("rstw_rdata_cleared", 64'(port.resp_rdata), 64'd0);
    @(posedge clk);
    #1;
    run_txn(1'b0, 16'h0023, 16'h0000, 16'h6000, "rstw_post_rd");

`ifdef MEM_PORT_BURST_EN
    // burst line fill with constant expectations
    push_exp(1'b0, 16'h0025, 16'h0000, 16'h6100, "burst_0025");
    start_req(1'b0, 16'h0025, 16'h0000, "burst_0025", 1'b0);
    time_txn(1'b0, 16'h0025, 16'h0000, 16, 12, "burst_0025");
    chk("burst_0025_line_const", 64'(port.resp_line), 64'h6200_F41C_6100_F01C);
    chk("burst_0025_rdata_const", 64'(port.resp_rdata), 64'h6100);

    // reset during beat 2 of a burst
    start_req(1'b0, 16'h0025, 16'h0000, "rstb", 1'b0);
    repeat (10) @(negedge clk);
    chk("rstb_readM_beat2",   64'(readM),   64'd1);
    chk("rstb_address_beat2", 64'(address), 64'h0026);
    #2 reset_n = 1'b0;
    #1;
    chk("rstb_readM_now", 64'(readM),           64'd0);
    chk("rstb_resp_now",  64'(port.resp_valid), 64'd0);
    chk("rstb_ready_now", 64'(port.req_ready),  64'd1);
    sb.delete();
    last_rdata = '0;
    rv = 0;
    repeat (3) begin
      @(negedge clk);
      if (port.resp_valid) rv++;
    end
    #2 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (port.resp_valid) rv++;
    end
    chk("rstb_no_resp", 64'(rv), 64'd0);
    @(posedge clk);
    #1;
    run_txn(1'b0, 16'h0026, 16'h0000, 16'hF41C, "rstb_post_rd");
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("readM_writeM_overlap", 64'(overlap), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
